// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b datapath types used by the memory arbiter:
//               16-bit word, 128-bit cache line and the arbiter state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================================
// Module      : mux2
// Description : Generic two-input multiplexer. o_f = i_sel ? i_b : i_a.
// Ports       : i_sel  - select
//               i_a    - input chosen when i_sel = 0
//               i_b    - input chosen when i_sel = 1
//               o_f    - selected output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2 #(
    parameter int WIDTH = 16
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_f
);

    assign o_f = i_sel ? i_b : i_a;

endmodule

`default_nettype wire

// File: rtl/pipeline_mem_arbiter.sv
// ============================================================================
// Module      : pipeline_mem_arbiter
// Description : Arbitrates one physical memory port between the instruction
//               cache (I-side, read only) and the data cache (D-side, read or
//               write). A request seen in IDLE is granted on the next edge;
//               the grant is held until pmem_resp or until the granted
//               requester drops its request, then one IDLE cycle follows.
// Ports       : clk, reset (synchronous, active high)
//               i_pmem_read/address  -> i_pmem_rdata/resp   (I-side)
//               d_pmem_read/write/address/wdata -> d_pmem_rdata/resp (D-side)
//               pmem_read/write/address/wdata  <- pmem_rdata/resp (memory)
// Config      : PMEM_ARB_ROUNDROBIN_EN - when defined, ties alternate using a
//               last-grant register (D wins the first tie after reset); when
//               undefined, D always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_mem_arbiter
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      reset,

    input  logic      i_pmem_read,
    input  lc3b_word  i_pmem_address,
    output lc3b_block i_pmem_rdata,
    output logic      i_pmem_resp,

    input  logic      d_pmem_read,
    input  logic      d_pmem_write,
    input  lc3b_word  d_pmem_address,
    input  lc3b_block d_pmem_wdata,
    output lc3b_block d_pmem_rdata,
    output logic      d_pmem_resp,

    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_block pmem_wdata,
    input  lc3b_block pmem_rdata,
    input  logic      pmem_resp
);

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic     w_i_req;
    logic     w_d_req;
    logic     w_tie_to_d;
    lc3b_word w_addr_i_or_zero;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUNDROBIN_EN
    // 1 = last grant went to D. Reset value 0 (I) so D takes the first tie.
    logic r_last_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == IDLE && w_next_state != IDLE) begin
            r_last_grant_d <= (w_next_state == SERVE_D);
        end
    end

    assign w_tie_to_d = ~r_last_grant_d;
`else
    assign w_tie_to_d = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and strobe/response decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (r_state)
            IDLE: begin
                // pmem_resp is deliberately not looked at here.
                if (w_i_req && w_d_req) begin
                    w_next_state = w_tie_to_d ? SERVE_D : SERVE_I;
                end else if (w_d_req) begin
                    w_next_state = SERVE_D;
                end else if (w_i_req) begin
                    w_next_state = SERVE_I;
                end
            end

            SERVE_I: begin
                pmem_read = i_pmem_read;
                if (!w_i_req) begin
                    // Requester abandoned the access: no response.
                    w_next_state = IDLE;
                end else if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            SERVE_D: begin
                pmem_read  = d_pmem_read;
                pmem_write = d_pmem_write;
                if (!w_d_req) begin
                    w_next_state = IDLE;
                end else if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address / data paths. The I-side leg of the mux is forced to zero
    // outside SERVE_I so that IDLE presents address 0.
    // ------------------------------------------------------------------------
    assign w_addr_i_or_zero = (r_state == SERVE_I) ? i_pmem_address : '0;

    mux2 #(
        .WIDTH (16)
    ) u_addr_mux (
        .i_sel (r_state == SERVE_D),
        .i_a   (w_addr_i_or_zero),
        .i_b   (d_pmem_address),
        .o_f   (pmem_address)
    );

    assign pmem_wdata   = (r_state == SERVE_D) ? d_pmem_wdata : '0;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_mem_arbiter.sv
// ============================================================================
// Module      : tb_pipeline_mem_arbiter
// Description : Directed scoreboard bench for pipeline_mem_arbiter. The
//               stimulus thread drives requests and the memory side, pushing
//               each expected response (side + line data) into a queue; a
//               negedge monitor pops and compares whenever a resp appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    pipeline_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         side_d;   // 1 = D-side response expected
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (i_pmem_resp || d_pmem_resp) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b, expected none",
                         i_pmem_resp, d_pmem_resp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_onehot", {127'b0, i_pmem_resp & d_pmem_resp}, 128'd0);
                chk("resp_side",   {127'b0, d_pmem_resp}, {127'b0, e.side_d});
                chk("resp_data",   e.side_d ? d_pmem_rdata : i_pmem_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic       exp_d [4];

        reset          = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = 16'h0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = 16'h0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("rst_pmem_read",  {127'b0, pmem_read},  128'd0);
        chk("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        chk("rst_pmem_addr",  {112'b0, pmem_address}, 128'd0);

        // ---------------- I-side read ----------------
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1230;
        settle();
        chk("i_latency_idle", {127'b0, pmem_read}, 128'd0);
        tick();
        chk("i_pmem_read",  {127'b0, pmem_read},  128'd1);
        chk("i_pmem_write", {127'b0, pmem_write}, 128'd0);
        chk("i_pmem_addr",  {112'b0, pmem_address}, 128'h1230);
        tick(); tick();
        pmem_rdata = {16{8'hA5}};
        pmem_resp  = 1'b1;
        exp_q.push_back('{side_d: 1'b0, data: {16{8'hA5}}});
        tick();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        settle();
        chk("i_after_resp_idle", {127'b0, pmem_read}, 128'd0);

        // ---------------- D-side write ----------------
        tick();
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h4000;
        d_pmem_wdata   = 128'h0123456789ABCDEF_0123456789ABCDEF;
        tick();
        chk("d_pmem_write", {127'b0, pmem_write}, 128'd1);
        chk("d_pmem_read",  {127'b0, pmem_read},  128'd0);
        chk("d_pmem_addr",  {112'b0, pmem_address}, 128'h4000);
        chk("d_pmem_wdata", pmem_wdata, 128'h0123456789ABCDEF_0123456789ABCDEF);
        tick();
        pmem_rdata = 128'h0;
        pmem_resp  = 1'b1;
        exp_q.push_back('{side_d: 1'b1, data: 128'h0});
        tick();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        settle();
        chk("d_after_resp_idle", {127'b0, pmem_write}, 128'd0);

        // ---------------- tie arbitration ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
`ifdef PMEM_ARB_ROUNDROBIN_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1111;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tie_grant_addr", {112'b0, pmem_address},
                exp_d[k] ? 128'h2222 : 128'h1111);
            pat        = 8'h10 + 8'(k);
            pmem_rdata = {16{pat}};
            pmem_resp  = 1'b1;
            exp_q.push_back('{side_d: exp_d[k], data: {16{pat}}});
            tick();
            pmem_resp = 1'b0;
            settle();
            chk("tie_idle_gap", {127'b0, pmem_read}, 128'd0);
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        tick();

        // ---------------- reset mid SERVE_D ----------------
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h0800;
        tick();
        chk("rstmid_grant", {127'b0, pmem_read}, 128'd1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        d_pmem_read = 1'b0;
        pmem_resp   = 1'b1;     // late response, must be ignored
        settle();
        chk("rstmid_read",  {127'b0, pmem_read},  128'd0);
        chk("rstmid_write", {127'b0, pmem_write}, 128'd0);
        chk("rstmid_addr",  {112'b0, pmem_address}, 128'd0);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk("rstmid_stay_idle", {127'b0, pmem_read}, 128'd0);

        // ---------------- spurious resp in IDLE ----------------
        pmem_resp = 1'b1;
        settle();
        chk("spurious_i_resp", {127'b0, i_pmem_resp}, 128'd0);
        chk("spurious_d_resp", {127'b0, d_pmem_resp}, 128'd0);
        tick();
        pmem_resp = 1'b0;
        settle();
        chk("spurious_no_state", {127'b0, pmem_read}, 128'd0);

        // ---------------- grant hold + early drop ----------------
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h3330;
        tick();
        chk("drop_grant", {127'b0, pmem_read}, 128'd1);
        d_pmem_write   = 1'b1;          // D arrives mid-transaction
        d_pmem_address = 16'h5550;
        d_pmem_wdata   = {8{16'hBEEF}};
        tick();
        chk("hold_grant_addr",  {112'b0, pmem_address}, 128'h3330);
        chk("hold_grant_write", {127'b0, pmem_write}, 128'd0);
        i_pmem_read = 1'b0;             // I abandons without resp
        settle();
        chk("drop_read_low", {127'b0, pmem_read}, 128'd0);
        tick();
        chk("drop_idle_write", {127'b0, pmem_write}, 128'd0);
        tick();
        chk("pending_d_write", {127'b0, pmem_write}, 128'd1);
        chk("pending_d_addr",  {112'b0, pmem_address}, 128'h5550);
        pmem_rdata = {8{16'h1357}};
        pmem_resp  = 1'b1;
        exp_q.push_back('{side_d: 1'b1, data: {8{16'h1357}}});
        tick();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        tick(); tick();

        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
